// File: rtl/mon_final_sub_pkg.sv
// Shared constants and FSM encoding for the Montgomery conditional final subtraction.
package mon_final_sub_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_WORDS  = 128;
  localparam int CNT_WIDTH  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECIDE = 2'd2,
    EMIT   = 2'd3
  } state_t;

endpackage

// File: rtl/mon_final_sub_if.sv
// Word-stream bus of the final-subtraction block: operand input side, result output side, status.
interface mon_final_sub_if #(
  parameter int DATA_WIDTH = mon_final_sub_pkg::DATA_WIDTH
);
  logic                  start;
  logic                  t_carry;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] t_word;
  logic [DATA_WIDTH-1:0] n_word;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_last;
  logic                  done;
  logic                  busy;

  modport master (
    output start, t_carry, in_valid, t_word, n_word, out_ready,
    input  in_ready, out_valid, r_word, r_last, done, busy
  );

  modport slave (
    input  start, t_carry, in_valid, t_word, n_word, out_ready,
    output in_ready, out_valid, r_word, r_last, done, busy
  );
endinterface

// File: rtl/mon_final_sub_sub_borrow.sv
// Combinational word subtractor with borrow in/out: {bout, d} = a - b - bin.
module mon_final_sub_sub_borrow #(
  parameter int DATA_WIDTH = mon_final_sub_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  bin,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  bout
);

  // One extra bit on the left catches the borrow out of the word.
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{DATA_WIDTH{1'b0}}, bin};

endmodule

// File: rtl/mon_final_sub.sv
// Word-serial conditional final subtraction: emits T - N when T >= N, else T, LS word first.
// Optional macro MON_FINAL_SUB_FLAG_EN adds the registered sub_taken output.
module mon_final_sub #(
  parameter int DATA_WIDTH = mon_final_sub_pkg::DATA_WIDTH,
  parameter int NUM_WORDS  = mon_final_sub_pkg::NUM_WORDS,
  parameter int CNT_WIDTH  = mon_final_sub_pkg::CNT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  mon_final_sub_if.slave bus
`ifdef MON_FINAL_SUB_FLAG_EN
  ,
  output logic          sub_taken
`endif
);
  import mon_final_sub_pkg::*;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  borrow;
  logic                  carry_q;
  logic                  sel_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] tbuf [NUM_WORDS];
  logic [DATA_WIDTH-1:0] dbuf [NUM_WORDS];

  logic [DATA_WIDTH-1:0] diff;
  logic                  bout;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  r_last_c;
  logic [DATA_WIDTH-1:0] r_word_c;
  logic                  in_fire;
  logic                  out_fire;

  mon_final_sub_sub_borrow #(.DATA_WIDTH(DATA_WIDTH)) u_sub_borrow (
    .a    (bus.t_word),
    .b    (bus.n_word),
    .bin  (borrow),
    .d    (diff),
    .bout (bout)
  );

  assign in_fire  = in_ready_c & bus.in_valid;
  assign out_fire = out_valid_c & bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    r_last_c    = 1'b0;
    r_word_c    = '0;
    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && cnt == LAST_IDX) state_nxt = DECIDE;
      end
      DECIDE: state_nxt = EMIT;
      EMIT: begin
        out_valid_c = 1'b1;
        r_word_c    = sel_q ? dbuf[cnt] : tbuf[cnt];
        r_last_c    = (cnt == LAST_IDX);
        if (bus.out_ready && r_last_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      borrow  <= 1'b0;
      carry_q <= 1'b0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          carry_q <= bus.t_carry;
          borrow  <= 1'b0;
          cnt     <= '0;
        end
        LOAD: if (in_fire) begin
          borrow <= bout;
          cnt    <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
        // A carry above the top word means T >= N no matter what the chain says.
        DECIDE: sel_q <= carry_q | ~borrow;
        EMIT: if (out_fire) begin
          cnt <= r_last_c ? '0 : cnt + 1'b1;
          if (r_last_c) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the word buffers have no reset; they are always fully rewritten in LOAD before EMIT reads them.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      tbuf[cnt] <= bus.t_word;
      dbuf[cnt] <= diff;
    end
  end

`ifdef MON_FINAL_SUB_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)                            sub_taken <= 1'b0;
    else if (state == IDLE && bus.start)  sub_taken <= 1'b0;
    else if (state == DECIDE)             sub_taken <= carry_q | ~borrow;
  end
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.r_word    = r_word_c;
  assign bus.r_last    = r_last_c;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mon_final_sub.sv
// Randomised bench for mon_final_sub (8-bit words, 4 words) against a whole-number reference model.
module tb_mon_final_sub;
  localparam int DW = 8;
  localparam int NW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mon_final_sub_if #(.DATA_WIDTH(DW)) bus ();

`ifdef MON_FINAL_SUB_FLAG_EN
  logic sub_taken;
`endif

  mon_final_sub #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MON_FINAL_SUB_FLAG_EN
    ,
    .sub_taken (sub_taken)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] cur_t [NW];
  logic [DW-1:0] cur_n [NW];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: treat T (with its carry bit) and N as plain integers.
  function automatic logic [DW*NW-1:0] model(input logic carry, output logic sel);
    logic [DW*NW:0] tv, nv, dv;
    tv = '0;
    nv = '0;
    for (int k = 0; k < NW; k++) begin
      tv[k*DW +: DW] = cur_t[k];
      nv[k*DW +: DW] = cur_n[k];
    end
    tv[DW*NW] = carry;
    sel = (tv >= nv);
    dv  = tv - nv;
    return sel ? dv[DW*NW-1:0] : tv[DW*NW-1:0];
  endfunction

  task automatic set_op(input logic [DW*NW-1:0] t, input logic [DW*NW-1:0] n);
    for (int k = 0; k < NW; k++) begin
      cur_t[k] = t[k*DW +: DW];
      cur_n[k] = n[k*DW +: DW];
    end
  endtask

  task automatic run_op(input logic carry, input bit stall, input bit mid_start);
    logic [DW*NW-1:0] exp_r;
    logic             exp_sel;
    int               i, j, guard;
    int unsigned      first_in, last_out;
    bit               first_seen, fire;
    exp_r      = model(carry, exp_sel);
    first_in   = 0;
    last_out   = 0;
    first_seen = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.t_carry = carry;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.t_carry = ~carry;
    check("busy_after_start", bus.busy, 1);

    i = 0;
    guard = 0;
    while (i < NW && guard < 100) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.t_word   = DW'($urandom);
        bus.n_word   = DW'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.t_word   = cur_t[i];
        bus.n_word   = cur_n[i];
      end
      bus.start = mid_start ? 1'($urandom_range(0, 1)) : 1'b0;
      fire = bus.in_valid && bus.in_ready;
      if (fire && !first_seen) begin
        first_in   = cyc;
        first_seen = 1;
      end
      @(negedge clk);
      if (fire) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check("load_beats", i, NW);
    check("decide_in_ready", bus.in_ready, 0);
    check("decide_out_valid", bus.out_valid, 0);

    j = 0;
    guard = 0;
    while (j < NW && guard < 100) begin
      bus.out_ready = (stall && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      if (bus.out_valid) begin
        check("r_word", bus.r_word, exp_r[j*DW +: DW]);
        check("r_last", bus.r_last, (j == NW - 1));
        if (bus.out_ready) begin
          last_out = cyc;
          j++;
        end
      end
      @(negedge clk);
      guard++;
    end
    bus.out_ready = 1'b0;
    check("emit_beats", j, NW);
    check("done_pulse", bus.done, 1);
    check("busy_idle", bus.busy, 0);
    check("out_valid_idle", bus.out_valid, 0);
    if (!stall) check("latency", last_out - first_in + 1, 2 * NW + 1);
`ifdef MON_FINAL_SUB_FLAG_EN
    check("sub_taken", sub_taken, exp_sel);
`endif
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    logic [DW*NW-1:0] rt, rn;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.t_carry   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.t_word    = '0;
    bus.n_word    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_r_last", bus.r_last, 0);
    check("rst_r_word", bus.r_word, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
`ifdef MON_FINAL_SUB_FLAG_EN
    check("rst_sub_taken", sub_taken, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("idle_ignores_valid", bus.busy, 0);
    bus.in_valid = 1'b0;

    // Directed cases, words packed LS word in the low byte.
    set_op(32'h05040302, 32'h01010101); run_op(1'b0, 0, 0);
    set_op(32'h01000000, 32'h01000001); run_op(1'b0, 0, 0);
    set_op(32'h01000000, 32'h01000000); run_op(1'b0, 0, 0);
    set_op(32'h02000000, 32'h00000001); run_op(1'b0, 0, 0);
    set_op(32'h00000005, 32'hFFFFFFF0); run_op(1'b1, 0, 0);
    set_op(32'h05040302, 32'h01010101); run_op(1'b0, 1, 1);

    for (int r = 0; r < 24; r++) begin
      rt = $urandom;
      case ($urandom_range(0, 3))
        0:       rn = rt;
        1:       rn = rt ^ (32'h1 << $urandom_range(0, 31));
        default: rn = $urandom;
      endcase
      set_op(rt, rn);
      run_op(1'($urandom_range(0, 3) == 0), 1, 1);
    end

    // Abort after two LOAD beats.
    set_op($urandom, $urandom);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.t_word   = cur_t[0];
    bus.n_word   = cur_n[0];
    @(negedge clk);
    bus.t_word   = cur_t[1];
    bus.n_word   = cur_n[1];
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_r_word", bus.r_word, 0);
    check("abort_r_last", bus.r_last, 0);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_done", bus.done, 0);
      @(negedge clk);
    end
    set_op(32'h05040302, 32'h01010101);
    run_op(1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mon_final_sub.md
Name: mon_final_sub

Overview:
- Word-serial conditional final subtraction for the Montgomery product (MonPro) path.
- Consumes the multiword MonPro result T, supplied least-significant word first, together with the modulus N words. It outputs T - N when T >= N, otherwise T.
- Uses a subtract-with-borrow word chain; sits downstream of the multiply-add stage and feeds the modexp ladder registers.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- NUM_WORDS, 128, words per operand (4096 / 32).
- CNT_WIDTH, 7, word counter width (clog2(NUM_WORDS)).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins an operation when in IDLE.
- t_carry  input  1  overflow bit of T above the top word; sampled with start.
- in_valid  input  1  t_word/n_word valid.
- in_ready  output  1  block accepts a word pair.
- t_word  input  DATA_WIDTH  current word of T.
- n_word  input  DATA_WIDTH  current word of N.
- out_valid  output  1  r_word valid.
- out_ready  input  1  downstream accepts r_word.
- r_word  output  DATA_WIDTH  result word, LS word first.
- r_last  output  1  high with the final result word.
- done  output  1  one-cycle pulse after the last result word is accepted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; in_ready, out_valid, r_last, done and busy are 0; r_word is 0; counter, borrow and select are cleared. Buffer contents are don't-care.
- FSM states: IDLE, LOAD, DECIDE, EMIT.
- IDLE: in_ready=0, and in_valid is ignored. On start, latch t_carry, clear borrow and counter, go to LOAD.
- LOAD: in_ready=1. On each handshake (in_valid & in_ready):
  - {b_out, d} = t_word - n_word - borrow, computed at DATA_WIDTH+1 bits; b_out is the MSB.
  - Store t_word in tbuf[cnt] and d in dbuf[cnt]; borrow <= b_out; cnt++.
  - When the handshake occurs at cnt == NUM_WORDS-1, go to DECIDE with cnt cleared.
- DECIDE: exactly 1 cycle. in_ready=0.
  - sel_d = t_carry | ~borrow.
  - T == N produces d = 0 with borrow 0, so the output is 0.
  - Go to EMIT.
- EMIT:
  - out_valid=1, r_word = sel_d ? dbuf[cnt] : tbuf[cnt], r_last = (cnt == NUM_WORDS-1).
  - r_word is stable while out_valid & ~out_ready.
  - On handshake cnt++. On the handshake with r_last, go to IDLE and pulse done for the next cycle.
- Latency: NUM_WORDS input handshakes + 1 DECIDE cycle, then the first r_word is valid. The minimum total is 2*NUM_WORDS+1 cycles from the first input beat to the last output beat.
- start while busy: ignored. in_valid gaps in LOAD: state held, borrow held.
- reset mid-operation: abort on the next edge and return to IDLE with all outputs at reset values. Partial data is discarded and no done pulse is issued.
- Buffers: two NUM_WORDS x DATA_WIDTH register/RAM arrays, written only in LOAD and read only in EMIT.

Optional Feature:
- Macro: MON_FINAL_SUB_FLAG_EN.
- Defined: adds output port sub_taken (1 bit). It is registered, equals sel_d from DECIDE until the next start, and resets to 0.
- Undefined: the port and its register are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds DATA_WIDTH, NUM_WORDS and CNT_WIDTH constants, plus the FSM state encoding (IDLE=0, LOAD=1, DECIDE=2, EMIT=3).
- One natural sub-module is sub_borrow, the combinational word subtractor: inputs a, b, bin; outputs d, bout. It mirrors the multiply-add word primitive.

Test Plan:
Bench uses DATA_WIDTH=8, NUM_WORDS=4; T and N words are listed LS-first.
- T>=N: T=02,03,04,05, N=01,01,01,01, t_carry=0 -> r=01,02,03,04; r_last on the 4th beat; done 1 cycle later.
- T<N: T=00,00,00,01, N=01,00,00,01 -> r=00,00,00,01 (T passed unchanged).
- T==N, and the borrow chain: T=00,00,00,01, N=00,00,00,01 -> r=00,00,00,00. Then T=00,00,00,02, N=01,00,00,00 -> r=FF,FF,FF,01.
- t_carry=1: T=05,00,00,00, N=F0,FF,FF,FF -> r=15,00,00,00 (sub_taken=1 when MON_FINAL_SUB_FLAG_EN).
- Backpressure and gaps: random in_valid and out_ready stalls -> same results as the stall-free case; r_word stable while stalled; a start asserted mid-LOAD is ignored.
- Reset after 2 LOAD beats -> busy=0, out_valid=0, no done pulse; a following clean operation produces correct results.
